wta_result_fifo: RTL and testbench

- Sits directly downstream of the k-NN search stage in the winner-take-all PWM design.
- Watches the nearest-neighbour one-hot `i_nn` and the k-nearest mask `i_knn`, detects round start and completion, and condenses each round into a 16-bit result word.
- Buffers results in a small FIFO for readback over the second SPI port; host pops words one at a time.

---
 rtl/wta_pkg.sv | 39 +++
 rtl/wta_result_fifo_if.sv | 16 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/wta_result_fifo.sv | 102 ++++++++++
 tb/tb_wta_result_fifo.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/wta_pkg.sv
// Shared definitions for the winner-take-all readback path: channel count,
// result-word field layout, round FSM states and mask helpers.
package wta_pkg;

    localparam int WTA_CH        = 8;
    localparam int RES_W         = 16;
    localparam int RES_TFLAG_BIT = 15;
    localparam int RES_CNT_LSB   = 11;
    localparam int RES_CNT_W     = 4;
    localparam int RES_IDX_LSB   = 8;
    localparam int RES_IDX_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT,
        ST_REARM
    } wta_state_e;

    function automatic logic [RES_CNT_W-1:0] popcount8(input logic [WTA_CH-1:0] v);
        logic [RES_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WTA_CH; i++) begin
            cnt = cnt + RES_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Scanning from the top down leaves the lowest set bit as the final winner.
    function automatic logic [RES_IDX_W-1:0] lsb_index8(input logic [WTA_CH-1:0] v);
        logic [RES_IDX_W-1:0] idx;
        idx = '0;
        for (int i = WTA_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = RES_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wta_result_fifo_if.sv
// Host-side readback bundle for the result FIFO (second SPI port).
interface wta_result_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          i_pop;
    logic          i_clr_ovf;
    logic          o_valid;
    logic [15:0]   o_data;
    logic [LW-1:0] o_level;
    logic          o_overflow;

    modport slave  (input  i_pop, i_clr_ovf, output o_valid, o_data, o_level, o_overflow);
    modport master (output i_pop, i_clr_ovf, input  o_valid, o_data, o_level, o_overflow);
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; pop is applied before push so a full FIFO can
// accept a write in the same cycle it is read.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<='; pointers and level are reset, they alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty entries are masked on the read side.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/wta_result_fifo.sv
// Condenses each k-NN round into a 16-bit result word and queues it for
// host readback; tracks dropped commits with a sticky overflow flag.
module wta_result_fifo
    import wta_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WTA_CH-1:0] i_nn,
    input  logic [WTA_CH-1:0] i_knn,
    input  logic [2:0]        i_k,
    wta_result_fifo_if.slave  rd,
    output logic              o_busy
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [11:0] T_LAST = 12'(TIMEOUT_CYC - 1);

    wta_state_e           state_q;
    logic [RES_IDX_W-1:0] idx_q;
    logic [WTA_CH-1:0]    knn_q;
    logic [11:0]          timer_q;
    logic                 tflag_q;
    logic                 ovf_q;

    logic [RES_CNT_W-1:0] k_eff;
    logic [RES_W-1:0]     entry;
    logic                 push, full, empty, drop;
    logic [LW-1:0]        level;

    assign k_eff = (i_k == 3'd0) ? RES_CNT_W'(1) : {1'b0, i_k};
    assign push  = (state_q == ST_COMMIT);
    assign drop  = push && full && !rd.i_pop;

    always_comb begin
        entry                                = '0;
        entry[RES_TFLAG_BIT]                 = tflag_q;
        entry[RES_CNT_LSB +: RES_CNT_W]      = popcount8(knn_q);
        entry[RES_IDX_LSB +: RES_IDX_W]      = idx_q;
        entry[WTA_CH-1:0]                    = knn_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            knn_q   <= '0;
            timer_q <= '0;
            tflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_nn != '0) begin
                        idx_q   <= lsb_index8(i_nn);
                        timer_q <= '0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    knn_q   <= i_knn;
                    timer_q <= timer_q + 12'd1;
                    if (popcount8(i_knn) >= k_eff) begin
                        tflag_q <= 1'b0;
                        state_q <= ST_COMMIT;
                    end else if (timer_q == T_LAST) begin
                        tflag_q <= 1'b1;
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: state_q <= ST_REARM;
                // Wait for the winner line to drop so a held i_nn cannot start a duplicate round.
                ST_REARM: if (i_nn == '0) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
            if (drop)               ovf_q <= 1'b1;
            else if (rd.i_clr_ovf)  ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (rd.i_pop),
        .data_i  (entry),
        .data_o  (rd.o_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign rd.o_valid    = !empty;
    assign rd.o_level    = level;
    assign rd.o_overflow = ovf_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wta_result_fifo.sv
// Bench for wta_result_fifo: directed scenarios with literal expectations plus
// a random phase, all outputs compared every cycle against a queue model.
module tb_wta_result_fifo;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_nn, i_knn;
    logic [2:0] i_k;
    logic       o_busy;

    wta_result_fifo_if #(.DEPTH(DEPTH)) rd ();

    wta_result_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_nn   (i_nn),
        .i_knn  (i_knn),
        .i_k    (i_k),
        .rd     (rd),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a round is "waiting" (0), "watching" (1), "committing" (2) or "held" (3).
    logic [15:0] mq[$];
    int  mode    = 0;
    int  m_idx   = 0;
    int  m_knn   = 0;
    int  m_seen  = 0;
    int  m_tflag = 0;
    int  m_keff  = 1;
    bit  m_ovf   = 0;
    bit  m_drop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mode  = 0;
            m_ovf = 0;
        end else begin
            m_drop = 0;
            if (rd.i_pop && mq.size() != 0) void'(mq.pop_front());
            if (mode == 2) begin
                if (mq.size() < DEPTH)
                    mq.push_back(16'(m_tflag * 32768 + $countones(8'(m_knn)) * 2048 + m_idx * 256 + m_knn));
                else
                    m_drop = 1;
            end
            if (m_drop) m_ovf = 1;
            else if (rd.i_clr_ovf) m_ovf = 0;
            case (mode)
                0: if (i_nn != 0) begin
                    for (int b = 7; b >= 0; b--) if (i_nn[b]) m_idx = b;
                    m_seen = 0;
                    mode   = 1;
                end
                1: begin
                    m_knn  = int'(i_knn);
                    m_seen = m_seen + 1;
                    m_keff = (i_k == 0) ? 1 : int'(i_k);
                    if ($countones(i_knn) >= m_keff) begin m_tflag = 0; mode = 2; end
                    else if (m_seen == TMO)          begin m_tflag = 1; mode = 2; end
                end
                2: mode = 3;
                default: if (i_nn == 0) mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_valid", 16'(rd.o_valid), 16'(mq.size() != 0));
            check("m_data",  rd.o_data, (mq.size() != 0) ? mq[0] : 16'h0000);
            check("m_level", 16'(rd.o_level), 16'(mq.size()));
            check("m_ovf",   16'(rd.o_overflow), 16'(m_ovf));
            check("m_busy",  16'(o_busy), 16'(mode != 0));
        end
    end

    task automatic do_round(input logic [7:0] nn, input logic [7:0] knn,
                            input logic [2:0] k, input bit pop_in_commit);
        i_k = k; i_nn = nn; i_knn = 8'h00;
        @(negedge clk);
        i_nn = 8'h00; i_knn = knn;
        @(negedge clk);
        rd.i_pop = pop_in_commit;
        @(negedge clk);
        rd.i_pop = 1'b0; i_knn = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_n(input int n);
        rd.i_pop = 1'b1;
        repeat (n) @(negedge clk);
        rd.i_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_nn = '0; i_knn = '0; i_k = '0;
        rd.i_pop = 1'b0; rd.i_clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        check("rst_valid", 16'(rd.o_valid), 16'h0);
        check("rst_data",  rd.o_data, 16'h0);
        check("rst_level", 16'(rd.o_level), 16'h0);
        check("rst_busy",  16'(o_busy), 16'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic round
        i_k = 3'd3; i_nn = 8'h04;
        @(negedge clk);
        check("basic_busy", 16'(o_busy), 16'h1);
        i_nn = 8'h00; i_knn = 8'h04;
        @(negedge clk); i_knn = 8'h14;
        @(negedge clk); i_knn = 8'h94;
        @(negedge clk);
        check("basic_valid_early", 16'(rd.o_valid), 16'h0);
        i_knn = 8'h00;
        @(negedge clk);
        check("basic_valid", 16'(rd.o_valid), 16'h1);
        check("basic_data",  rd.o_data, 16'h1A94);
        check("basic_level", 16'(rd.o_level), 16'h1);
        pop_n(1);
        check("basic_pop_level", 16'(rd.o_level), 16'h0);

        // Timeout after exactly TMO collect cycles
        i_k = 3'd5; i_nn = 8'h01; i_knn = 8'h03;
        repeat (TMO + 1) @(negedge clk);
        check("tmo_valid_early", 16'(rd.o_valid), 16'h0);
        @(negedge clk);
        check("tmo_data", rd.o_data, 16'h9003);
        i_nn = 8'h00; i_knn = 8'h00;
        @(negedge clk);
        pop_n(1);

        // Held winner line produces a single entry; then pop past empty
        i_k = 3'd1; i_nn = 8'h08; i_knn = 8'h08;
        repeat (50) @(negedge clk);
        check("rearm_level", 16'(rd.o_level), 16'h1);
        check("rearm_data",  rd.o_data, 16'h0B08);
        i_nn = 8'h00; i_knn = 8'h00;
        @(negedge clk);
        pop_n(2);
        check("empty_pop_level", 16'(rd.o_level), 16'h0);
        check("empty_pop_data",  rd.o_data, 16'h0);

        // Fill and overflow
        for (int i = 0; i < 5; i++) do_round(8'(1 << i), 8'(1 << i), 3'd1, 1'b0);
        check("full_level", 16'(rd.o_level), 16'h4);
        check("full_ovf",   16'(rd.o_overflow), 16'h1);
        check("full_head",  rd.o_data, 16'h0801);
        rd.i_clr_ovf = 1'b1;
        @(negedge clk);
        rd.i_clr_ovf = 1'b0;
        check("clr_ovf", 16'(rd.o_overflow), 16'h0);

        // Push and pop together while full
        do_round(8'h80, 8'hFF, 3'd7, 1'b1);
        check("pp_level", 16'(rd.o_level), 16'h4);
        check("pp_ovf",   16'(rd.o_overflow), 16'h0);
        check("pp_head",  rd.o_data, 16'h0902);
        pop_n(3);
        check("pp_tail",  rd.o_data, 16'h47FF);
        pop_n(1);

        // Reset in the middle of a round
        i_k = 3'd7; i_nn = 8'h01; i_knn = 8'h01;
        @(negedge clk);
        i_nn = 8'h00;
        repeat (2) @(negedge clk);
        check("mid_busy", 16'(o_busy), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_knn = 8'h00;
        check("mid_rst_busy",  16'(o_busy), 16'h0);
        check("mid_rst_level", 16'(rd.o_level), 16'h0);
        do_round(8'h30, 8'h30, 3'd2, 1'b0);
        check("post_rst_data", rd.o_data, 16'h1430);
        pop_n(1);

        // Random traffic against the model
        repeat (600) begin
            @(negedge clk);
            i_nn         = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
            i_knn        = 8'($urandom);
            i_k          = 3'($urandom);
            rd.i_pop     = ($urandom % 3 == 0);
            rd.i_clr_ovf = ($urandom % 16 == 0);
            rst          = ($urandom % 200 == 0);
        end
        @(negedge clk);
        rst = 1'b0; i_nn = '0; i_knn = '0; rd.i_pop = 1'b0; rd.i_clr_ovf = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
